fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//   Drives the 16-bit instruction-memory address and turns the memory's registered
//   1-cycle read into a valid/ready instruction stream for decode.
//   Owns the PC: sequential increment with wrap, branch/jump redirect, halt.
//   2-entry {pc,inst} buffer absorbs decode back-pressure without losing in-flight reads.
// PARAMETERS
//   ADDR_W     16   instruction address / PC width
//   INST_W     32   instruction word width
//   PC_RESET   0    PC after reset and after wrap
//   ADDR_LAST  50   last valid instruction address; PC wraps to PC_RESET after it
// PORTS
//   clk         in   1       clock, all state on posedge
//   rst         in   1       synchronous, active-high reset
//   mem_addr    out  ADDR_W  address to instruction memory (registered, = PC)
//   mem_data    in   INST_W  memory read data, reflects address sampled on previous edge
//   mem_valid   in   1       memory data valid (low during/just after reset)
//   redir_valid in   1       redirect request (taken branch/jump), single-cycle pulse
//   redir_pc    in   ADDR_W  redirect target
//   halt        in   1       level; stop issuing new fetches while high
//   inst_valid  out  1       buffer head holds a valid instruction
//   inst        out  INST_W  head instruction word
//   inst_pc     out  ADDR_W  address the head instruction was fetched from
//   inst_ready  in   1       decode accepts head this cycle
//   busy        out  1       a read is in flight or buffer non-empty
// BEHAVIOUR
//   Reset: pc=mem_addr=PC_RESET, state=BOOT, buffer empty, inflight=0,
//     inst_valid=0, inst=0, inst_pc=0, busy=0.
//   FSM: BOOT -> RUN after one cycle (no issue in BOOT).
//     RUN -> HALT when halt=1; HALT -> RUN when halt=0. No issue in HALT.
//   Issue at edge E when state=RUN, halt=0, redir_valid=0, (count+inflight-pop)<2:
//     memory samples mem_addr=pc; inflight<=1; inflight_pc<=pc; pc<=next_pc.
//   next_pc = (pc==ADDR_LAST) ? PC_RESET : pc+1 (mod 2^ADDR_W).
//   Capture: inflight=1 & mem_valid=1 -> push {inflight_pc, mem_data}; inflight clears
//     unless a new issue happens at the same edge.
//     inflight=1 & mem_valid=0 -> hold inflight, no push.
//   Pop: inst_valid & inst_ready -> head removed at edge.
//     Push and pop may occur in the same edge.
//   Latency: address issued at edge E, instruction at head no earlier than after E+1.
//     Steady state with inst_ready=1: 1 instruction/cycle.
//   Credit rule guarantees no push into a full buffer; overflow is a design bug (assert).
//   Redirect (redir_valid=1, any state except BOOT) takes priority over everything:
//     buffer flushed, pop ignored, inflight read killed (its data never pushed),
//     pc<=redir_pc, no issue that edge. First redirected issue at the next edge if RUN.
//     In HALT the pc updates and the FSM stays in HALT.
//   Halt with a read in flight: capture still completes; buffer still drains via pop.
//   redir_pc beyond ADDR_LAST: fetched as given; wrap applies only on increment from ADDR_LAST.
//   rst mid-operation: all state returns to reset values at that edge; in-flight data dropped.
//   inst/inst_pc hold last value when buffer empty (inst_valid=0); only inst_valid is meaningful.
// TESTING
//   Reset, inst_ready=1, mem returns addr as data -> inst_pc 0,1,2,3 on consecutive cycles;
//     inst_valid is first seen 2 cycles after rst drops.
//   inst_ready=0 for 5 cycles -> 2 entries buffered, mem_addr frozen; on release pc order
//     unbroken with no duplicates or drops.
//   Redirect to 0x0020 while buffer full + read in flight -> next inst_pc=0x0020;
//     no stale pc delivered.
//   Run from PC 49 -> inst_pc 49,50,0,1 (wrap at ADDR_LAST=50).
//   halt=1 with read in flight -> that instruction still delivered; no new mem_addr change
//     until halt=0.
//   rst asserted mid-stream with inst_valid=1 -> next cycle inst_valid=0, mem_addr=0, busy=0.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer_if
//  Description : Memory, redirect/halt and instruction-stream signals of the
//                fetch sequencer. The master side is the sequencer; the slave
//                side is the instruction memory plus decode.
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int INST_W = 32
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_data;
    logic              mem_valid;
    logic              redir_valid;
    logic [ADDR_W-1:0] redir_pc;
    logic              halt;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;
    logic              busy;

    modport master (
        output mem_addr,
        input  mem_data, mem_valid,
        input  redir_valid, redir_pc, halt,
        output inst_valid, inst, inst_pc,
        input  inst_ready,
        output busy
    );

    modport slave (
        input  mem_addr,
        output mem_data, mem_valid,
        output redir_valid, redir_pc, halt,
        input  inst_valid, inst, inst_pc,
        output inst_ready,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Owns the PC, drives the instruction-memory address and turns
//                the memory's 1-cycle registered read into a valid/ready
//                instruction stream. A 2-entry {pc,inst} buffer absorbs decode
//                back-pressure; redirects flush everything in flight.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
    parameter int ADDR_W    = 16,
    parameter int INST_W    = 32,
    parameter int PC_RESET  = 0,
    parameter int ADDR_LAST = 50
) (
    input  logic               clk,
    input  logic               rst,
    fetch_sequencer_if.master  bus
);

    localparam logic [ADDR_W-1:0] C_PC_RESET  = ADDR_W'(PC_RESET);
    localparam logic [ADDR_W-1:0] C_ADDR_LAST = ADDR_W'(ADDR_LAST);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic [1:0]        count_q;
    // Entry 0 is always the head; entry 1 shifts into it on pop.
    logic [ADDR_W-1:0] pc0_q, pc1_q;
    logic [INST_W-1:0] inst0_q, inst1_q;

    logic [ADDR_W-1:0] next_pc_d;
    logic              redir_d;
    logic              pop_d;
    logic              push_d;
    logic              issue_d;
    logic [2:0]        occupancy_d;

    // Per-edge decisions: redirect, pop, capture (push) and issue credit.
    always_comb begin
        next_pc_d   = (pc_q == C_ADDR_LAST) ? C_PC_RESET : pc_q + ADDR_W'(1);
        redir_d     = bus.redir_valid && (state_q != ST_BOOT);
        pop_d       = (count_q != 2'd0) && bus.inst_ready;
        push_d      = inflight_q && bus.mem_valid;
        occupancy_d = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_d};
        // A stalled read (mem_valid low) blocks a new issue so its address is
        // never overwritten before the data arrives.
        issue_d     = (state_q == ST_RUN) && !bus.halt && !redir_d &&
                      (occupancy_d < 3'd2) && (!inflight_q || bus.mem_valid);
    end

    // FSM, PC, in-flight tracking and buffer update in one sequential block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= C_PC_RESET;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= 2'd0;
            pc0_q         <= '0;
            pc1_q         <= '0;
            inst0_q       <= '0;
            inst1_q       <= '0;
        end else begin
            // A redirect leaves the FSM where it is (HALT stays HALT).
            if (!redir_d) begin
                case (state_q)
                    ST_BOOT: state_q <= ST_RUN;
                    ST_RUN:  if (bus.halt)  state_q <= ST_HALT;
                    ST_HALT: if (!bus.halt) state_q <= ST_RUN;
                    default: state_q <= ST_BOOT;
                endcase
            end

            if (redir_d) begin
                count_q    <= 2'd0;
                inflight_q <= 1'b0;
                pc_q       <= bus.redir_pc;
            end else begin
                if (issue_d) begin
                    inflight_q    <= 1'b1;
                    inflight_pc_q <= pc_q;
                    pc_q          <= next_pc_d;
                end else if (push_d) begin
                    inflight_q <= 1'b0;
                end

                case ({push_d, pop_d})
                    2'b10:   count_q <= count_q + 2'd1;
                    2'b01:   count_q <= count_q - 2'd1;
                    default: count_q <= count_q;
                endcase

                if (push_d && ((count_q == 2'd0) || (count_q == 2'd1 && pop_d))) begin
                    pc0_q   <= inflight_pc_q;
                    inst0_q <= bus.mem_data;
                end else if (pop_d && (count_q == 2'd2)) begin
                    pc0_q   <= pc1_q;
                    inst0_q <= inst1_q;
                end

                if (push_d && ((count_q == 2'd1 && !pop_d) || (count_q == 2'd2 && pop_d))) begin
                    pc1_q   <= inflight_pc_q;
                    inst1_q <= bus.mem_data;
                end
            end
        end
    end

    // The issue credit must make a push into a full buffer impossible.
    always_ff @(posedge clk) begin
        if (!rst && !redir_d) begin
            assert (!(push_d && !pop_d && (count_q == 2'd2)));
        end
    end

    assign bus.mem_addr   = pc_q;
    assign bus.inst_valid = (count_q != 2'd0);
    assign bus.inst       = inst0_q;
    assign bus.inst_pc    = pc0_q;
    assign bus.busy       = inflight_q || (count_q != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Self-checking bench for fetch_sequencer. A negedge monitor
//                logs accepted instructions and redirects; the reference is
//                program order (increment with wrap at 50, restart at each
//                redirect target) plus a fixed memory contents function.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

    logic clk;
    logic rst;

    fetch_sequencer_if #(.ADDR_W(16), .INST_W(32)) bus ();

    fetch_sequencer #(
        .ADDR_W(16), .INST_W(32), .PC_RESET(0), .ADDR_LAST(50)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          is_redir;
        logic [15:0] pc;
        logic [31:0] word;
        int          cyc;
    } ev_t;

    ev_t evq[$];
    int  cyc;
    int  n_cmp;
    int  n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    function automatic logic [15:0] ref_next(logic [15:0] a);
        return (a == 16'd50) ? 16'd0 : a + 16'd1;
    endfunction

    // Instruction memory: registered 1-cycle read, invalid during reset.
    always @(posedge clk) begin
        bus.mem_data  <= mem_word(bus.mem_addr);
        bus.mem_valid <= !rst;
    end

    // Monitor: what the next edge will accept or redirect.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (bus.redir_valid)
                evq.push_back('{1'b1, bus.redir_pc, 32'h0, cyc});
            else if (bus.inst_valid && bus.inst_ready)
                evq.push_back('{1'b0, bus.inst_pc, bus.inst, cyc});
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_redirect(logic [15:0] target);
        bus.redir_valid = 1'b1;
        bus.redir_pc    = target;
        tick(1);
        bus.redir_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.redir_valid = 1'b0; bus.redir_pc = '0; bus.halt = 1'b0; bus.inst_ready = 1'b0;
        tick(3);
        n_cmp++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %0b want 0", bus.inst_valid); end
        n_cmp++; if (bus.mem_addr !== 16'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %0h want 0", bus.mem_addr); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        n_cmp++; if (bus.inst !== 32'd0) begin n_fail++; $display("FAIL reset_inst: got %0h want 0", bus.inst); end
        n_cmp++; if (bus.inst_pc !== 16'd0) begin n_fail++; $display("FAIL reset_inst_pc: got %0h want 0", bus.inst_pc); end
    endtask

    task automatic test_startup();
        int first;
        first = -1;
        evq.delete();
        bus.inst_ready = 1'b1;
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            if (first < 0 && bus.inst_valid) first = i;
        end
        // Edge 1 leaves BOOT, edge 2 issues PC 0, edge 3 captures: valid two
        // edges after the first edge that sees rst low.
        n_cmp++; if (first - 1 !== 2) begin n_fail++; $display("FAIL startup_latency: got %0d want 2", first - 1); end
        n_cmp++; if (evq.size() < 8) begin n_fail++; $display("FAIL startup_count: got %0d want >=8", evq.size()); end
        for (int k = 0; k < 8 && k < evq.size(); k++) begin
            n_cmp++; if (evq[k].pc !== 16'(k)) begin n_fail++; $display("FAIL startup_pc[%0d]: got %0h want %0h", k, evq[k].pc, k); end
            n_cmp++; if (evq[k].word !== mem_word(16'(k))) begin n_fail++; $display("FAIL startup_inst[%0d]: got %0h want %0h", k, evq[k].word, mem_word(16'(k))); end
            if (k > 0) begin
                n_cmp++; if (evq[k].cyc !== evq[k-1].cyc + 1) begin n_fail++; $display("FAIL startup_rate[%0d]: got gap %0d want 1", k, evq[k].cyc - evq[k-1].cyc); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] a0;
        int          sz0;
        bus.inst_ready = 1'b0;
        a0 = bus.mem_addr;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            n_cmp++; if (bus.mem_addr !== a0) begin n_fail++; $display("FAIL bp_addr_frozen[%0d]: got %0h want %0h", i, bus.mem_addr, a0); end
        end
        n_cmp++; if (bus.inst_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %0b want 1", bus.inst_valid); end
        sz0 = evq.size();
        bus.inst_ready = 1'b1;
        tick(6);
        n_cmp++; if (evq.size() < sz0 + 5) begin n_fail++; $display("FAIL bp_resume_count: got %0d want >=%0d", evq.size(), sz0 + 5); end
        if (evq.size() >= sz0 + 2) begin
            n_cmp++; if (evq[sz0+1].cyc !== evq[sz0].cyc + 1) begin n_fail++; $display("FAIL bp_drain_rate: got gap %0d want 1", evq[sz0+1].cyc - evq[sz0].cyc); end
        end
        // No wrap yet and no redirects: delivery index equals PC.
        for (int k = 0; k < evq.size(); k++) begin
            n_cmp++; if (evq[k].pc !== 16'(k)) begin n_fail++; $display("FAIL bp_order[%0d]: got %0h want %0h", k, evq[k].pc, k); end
        end
    endtask

    task automatic test_redirect();
        int mark;
        bus.inst_ready = 1'b0;
        tick(3);
        n_cmp++; if (bus.inst_valid !== 1'b1) begin n_fail++; $display("FAIL redir_pre_valid: got %0b want 1", bus.inst_valid); end
        mark = evq.size();
        bus.inst_ready = 1'b1;
        pulse_redirect(16'h0020);
        n_cmp++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got %0b want 0", bus.inst_valid); end
        n_cmp++; if (bus.mem_addr !== 16'h0020) begin n_fail++; $display("FAIL redir_addr: got %0h want 20", bus.mem_addr); end
        tick(6);
        n_cmp++; if (evq.size() < mark + 5) begin n_fail++; $display("FAIL redir_count: got %0d want >=%0d", evq.size(), mark + 5); end
        for (int k = 0; k < 4 && mark + 1 + k < evq.size(); k++) begin
            n_cmp++; if (evq[mark+1+k].pc !== 16'h0020 + 16'(k)) begin n_fail++; $display("FAIL redir_pc[%0d]: got %0h want %0h", k, evq[mark+1+k].pc, 16'h0020 + 16'(k)); end
        end
    endtask

    task automatic test_wrap();
        int          mark;
        logic [15:0] want [4];
        want = '{16'd49, 16'd50, 16'd0, 16'd1};
        mark = evq.size();
        pulse_redirect(16'd49);
        tick(7);
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (evq[mark+1+k].pc !== want[k]) begin n_fail++; $display("FAIL wrap_pc[%0d]: got %0h want %0h", k, evq[mark+1+k].pc, want[k]); end
        end
    endtask

    task automatic test_redirect_beyond();
        int mark;
        mark = evq.size();
        pulse_redirect(16'd100);
        tick(7);
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (evq[mark+1+k].pc !== 16'd100 + 16'(k)) begin n_fail++; $display("FAIL beyond_pc[%0d]: got %0h want %0h", k, evq[mark+1+k].pc, 16'd100 + 16'(k)); end
        end
    endtask

    task automatic test_halt();
        logic [15:0] a0;
        logic [15:0] got;
        int          mark2;
        bus.halt = 1'b1;
        a0 = bus.mem_addr;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            n_cmp++; if (bus.mem_addr !== a0) begin n_fail++; $display("FAIL halt_addr_frozen[%0d]: got %0h want %0h", i, bus.mem_addr, a0); end
        end
        n_cmp++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL halt_drained: got %0b want 0", bus.inst_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL halt_busy: got %0b want 0", bus.busy); end
        // The read in flight when halt rose is the last one delivered.
        n_cmp++; if (ref_next(evq[evq.size()-1].pc) !== a0) begin n_fail++; $display("FAIL halt_inflight_delivered: got last %0h want %0h", evq[evq.size()-1].pc, a0 - 16'd1); end
        mark2 = evq.size();
        bus.halt = 1'b0;
        tick(5);
        got = 'x;
        if (evq.size() > mark2) got = evq[mark2].pc;
        n_cmp++; if (got !== a0) begin n_fail++; $display("FAIL halt_resume_pc: got %0h want %0h", got, a0); end
    endtask

    task automatic test_reset_mid();
        int          mark;
        logic [15:0] got;
        tick(3);
        n_cmp++; if (bus.inst_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid: got %0b want 1", bus.inst_valid); end
        rst = 1'b1;
        tick(1);
        n_cmp++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %0b want 0", bus.inst_valid); end
        n_cmp++; if (bus.mem_addr !== 16'd0) begin n_fail++; $display("FAIL rstmid_addr: got %0h want 0", bus.mem_addr); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %0b want 0", bus.busy); end
        mark = evq.size();
        rst = 1'b0;
        tick(6);
        got = 'x;
        if (evq.size() > mark) got = evq[mark].pc;
        n_cmp++; if (got !== 16'd0) begin n_fail++; $display("FAIL rstmid_restart_pc: got %0h want 0", got); end
    endtask

    task automatic test_random();
        int          mark;
        int          delivered;
        logic [15:0] pre_addr;
        logic [15:0] exp_pc;
        logic        h, r;
        delivered = 0;
        mark = evq.size();
        pulse_redirect(16'($urandom_range(0, 50)));
        for (int i = 0; i < 400; i++) begin
            bus.inst_ready  = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) bus.halt = !bus.halt;
            bus.redir_valid = ($urandom_range(0, 24) == 0);
            bus.redir_pc    = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(45, 50))
                                                          : 16'($urandom_range(0, 120));
            pre_addr = bus.mem_addr;
            h = bus.halt;
            r = bus.redir_valid;
            tick(1);
            if (h && !r) begin
                n_cmp++; if (bus.mem_addr !== pre_addr) begin n_fail++; $display("FAIL rnd_halt_addr[%0d]: got %0h want %0h", i, bus.mem_addr, pre_addr); end
            end
            if (bus.inst_valid) begin
                n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %0b want 1", i, bus.busy); end
            end
        end
        bus.halt = 1'b0; bus.redir_valid = 1'b0; bus.inst_ready = 1'b1;
        tick(10);
        n_cmp++; if (bus.inst_valid !== 1'b1) begin n_fail++; $display("FAIL rnd_final_stream: got %0b want 1", bus.inst_valid); end
        exp_pc = '0;
        for (int k = mark; k < evq.size(); k++) begin
            if (evq[k].is_redir) begin
                exp_pc = evq[k].pc;
            end else begin
                delivered++;
                n_cmp++; if (evq[k].pc !== exp_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %0h want %0h", k, evq[k].pc, exp_pc); end
                n_cmp++; if (evq[k].word !== mem_word(evq[k].pc)) begin n_fail++; $display("FAIL rnd_inst[%0d]: got %0h want %0h", k, evq[k].word, mem_word(evq[k].pc)); end
                exp_pc = ref_next(exp_pc);
            end
        end
        n_cmp++; if (delivered < 50) begin n_fail++; $display("FAIL rnd_liveness: got %0d want >=50", delivered); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_redirect_beyond();
        test_halt();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
